// File: rtl/mem_stage.sv
// Memory pipeline stage: issues loads/stores to the data memory, steers byte lanes,
// detects misalignment, bus errors and timeouts, and registers results into the WB latch.
module mem_stage #(
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_mem_v,
    input  logic [63:0] i_mem_ir,
    input  logic [63:0] i_mem_npc,
    input  logic [63:0] i_mem_alu_result,
    input  logic [63:0] i_mem_sr2,
    input  logic [63:0] i_mem_csrfd,
    input  logic [63:0] i_mem_rfd,
    input  logic [4:0]  i_mem_drid,
    input  logic        i_mem_pc_mux,
    input  logic        i_mem_ecall,
    input  logic        i_flush,
    input  logic        i_dmem_ready,
    input  logic [63:0] i_dmem_rdata,
    input  logic        i_dmem_err,
    output logic        o_dmem_req,
    output logic        o_dmem_we,
    output logic [63:0] o_dmem_addr,
    output logic [63:0] o_dmem_wdata,
    output logic [7:0]  o_dmem_wstrb,
    output logic        o_mem_stall,
    output logic        o_wb_v,
    output logic [63:0] o_wb_npc,
    output logic [63:0] o_wb_mem_result,
    output logic [63:0] o_wb_alu_result,
    output logic [63:0] o_wb_ir,
    output logic        o_wb_pc_mux,
    output logic [63:0] o_wb_csrfd,
    output logic [63:0] o_wb_rfd,
    output logic [4:0]  o_wb_drid,
    output logic        o_wb_ecall,
    output logic        o_mem_lam,
    output logic        o_mem_laf,
    output logic        o_mem_sam,
    output logic        o_mem_saf
);

    localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CW-1:0] TC_LAST = CW'(TIMEOUT_CYCLES - 1);

    // IDLE: accept/issue | BUSY: request outstanding | DRAIN: flushed, waiting for the bus to finish
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BUSY  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [63:0] r_addr;
    logic [63:0] r_wdata;
    logic [7:0]  r_wstrb;
    logic        r_we;
    logic [2:0]  r_funct3;
    logic [2:0]  r_off;

    logic [6:0]  w_opcode;
    logic [2:0]  w_funct3;
    logic [2:0]  w_off;
    logic        w_is_load;
    logic        w_is_store;
    logic        w_misal;
    logic        w_aligned_op;
    logic [7:0]  w_size_mask;
    logic [2:0]  w_align_mask;
    logic        w_timeout;
    logic        w_req;
    logic        w_we;
    logic [63:0] w_addr;
    logic [63:0] w_wdata;
    logic [7:0]  w_wstrb;
    logic        w_stall;
    logic        w_done;
    logic        w_fault;
    logic [2:0]  w_sel_off;
    logic [2:0]  w_sel_f3;
    logic        w_sel_we;
    logic [63:0] w_shifted;
    logic [63:0] w_load_data;
    logic        w_wb_v_nxt;

    assign w_opcode     = i_mem_ir[6:0];
    assign w_funct3     = i_mem_ir[14:12];
    assign w_off        = i_mem_alu_result[2:0];
    assign w_is_load    = i_mem_v & (w_opcode == 7'b0000011);
    assign w_is_store   = i_mem_v & (w_opcode == 7'b0100011) & ~w_funct3[2];
    assign w_misal      = |(w_off & w_align_mask);
    assign w_aligned_op = (w_is_load | w_is_store) & ~w_misal;
    assign w_timeout    = (r_cnt == TC_LAST);
    assign w_wb_v_nxt   = i_mem_v & ~i_flush;

    always_comb begin
        w_size_mask  = 8'h01;
        w_align_mask = 3'b000;
        case (w_funct3[1:0])
            2'b00: begin w_size_mask = 8'h01; w_align_mask = 3'b000; end
            2'b01: begin w_size_mask = 8'h03; w_align_mask = 3'b001; end
            2'b10: begin w_size_mask = 8'h0F; w_align_mask = 3'b011; end
            default: begin w_size_mask = 8'hFF; w_align_mask = 3'b111; end
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        w_req       = 1'b0;
        w_we        = 1'b0;
        w_addr      = '0;
        w_wdata     = '0;
        w_wstrb     = '0;
        w_stall     = 1'b0;
        w_done      = 1'b0;
        w_fault     = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_aligned_op && !i_flush) begin
                    w_req   = 1'b1;
                    w_we    = w_is_store;
                    w_addr  = {i_mem_alu_result[63:3], 3'b000};
                    w_wdata = i_mem_sr2 << {w_off, 3'b000};
                    w_wstrb = w_size_mask << w_off;
                    if (i_dmem_ready) begin
                        w_done  = 1'b1;
                        w_fault = i_dmem_err;
                    end else begin
                        w_stall     = 1'b1;
                        w_state_nxt = BUSY;
                    end
                end
            end
            BUSY: begin
                w_req   = 1'b1;
                w_we    = r_we;
                w_addr  = r_addr;
                w_wdata = r_wdata;
                w_wstrb = r_wstrb;
                if (i_dmem_ready) begin
                    w_done      = 1'b1;
                    w_fault     = i_dmem_err;
                    w_state_nxt = IDLE;
                end else if (w_timeout) begin
                    w_done      = 1'b1;
                    w_fault     = 1'b1;
                    w_state_nxt = IDLE;
                end else begin
                    w_stall = 1'b1;
                    if (i_flush) w_state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                w_req   = 1'b1;
                w_we    = r_we;
                w_addr  = r_addr;
                w_wdata = r_wdata;
                w_wstrb = r_wstrb;
                w_stall = 1'b1;
                if (i_dmem_ready || w_timeout) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
        // Reset drops the bus request and the stall in the same cycle it is asserted.
        if (i_reset) begin
            w_req   = 1'b0;
            w_we    = 1'b0;
            w_addr  = '0;
            w_wdata = '0;
            w_wstrb = '0;
            w_stall = 1'b0;
        end
    end

    assign o_dmem_req   = w_req;
    assign o_dmem_we    = w_we;
    assign o_dmem_addr  = w_addr;
    assign o_dmem_wdata = w_wdata;
    assign o_dmem_wstrb = w_wstrb;
    assign o_mem_stall  = w_stall;

    assign w_sel_off = (r_state == IDLE) ? w_off : r_off;
    assign w_sel_f3  = (r_state == IDLE) ? w_funct3 : r_funct3;
    assign w_sel_we  = (r_state == IDLE) ? w_is_store : r_we;
    assign w_shifted = i_dmem_rdata >> {w_sel_off, 3'b000};

    always_comb begin
        w_load_data = w_shifted;
        case (w_sel_f3)
            3'b000:  w_load_data = {{56{w_shifted[7]}},  w_shifted[7:0]};
            3'b001:  w_load_data = {{48{w_shifted[15]}}, w_shifted[15:0]};
            3'b010:  w_load_data = {{32{w_shifted[31]}}, w_shifted[31:0]};
            3'b100:  w_load_data = {56'd0, w_shifted[7:0]};
            3'b101:  w_load_data = {48'd0, w_shifted[15:0]};
            3'b110:  w_load_data = {32'd0, w_shifted[31:0]};
            default: w_load_data = w_shifted;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr   <= '0;
            r_wdata  <= '0;
            r_wstrb  <= '0;
            r_we     <= 1'b0;
            r_funct3 <= '0;
            r_off    <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE) begin
                r_cnt <= '0;
                if (w_state_nxt == BUSY) begin
                    r_addr   <= w_addr;
                    r_wdata  <= w_wdata;
                    r_wstrb  <= w_wstrb;
                    r_we     <= w_we;
                    r_funct3 <= w_funct3;
                    r_off    <= w_off;
                end
            end else begin
                r_cnt <= r_cnt + CW'(1);
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_wb_v          <= 1'b0;
            o_wb_npc        <= '0;
            o_wb_mem_result <= '0;
            o_wb_alu_result <= '0;
            o_wb_ir         <= '0;
            o_wb_pc_mux     <= 1'b0;
            o_wb_csrfd      <= '0;
            o_wb_rfd        <= '0;
            o_wb_drid       <= '0;
            o_wb_ecall      <= 1'b0;
            o_mem_lam       <= 1'b0;
            o_mem_laf       <= 1'b0;
            o_mem_sam       <= 1'b0;
            o_mem_saf       <= 1'b0;
        end else if (!w_stall) begin
            o_wb_v          <= w_wb_v_nxt;
            o_wb_npc        <= i_mem_npc;
            o_wb_alu_result <= i_mem_alu_result;
            o_wb_ir         <= i_mem_ir;
            o_wb_pc_mux     <= i_mem_pc_mux;
            o_wb_csrfd      <= i_mem_csrfd;
            o_wb_rfd        <= i_mem_rfd;
            o_wb_drid       <= i_mem_drid;
            o_wb_ecall      <= i_mem_ecall;
            o_wb_mem_result <= (w_wb_v_nxt && w_done && !w_fault && !w_sel_we) ? w_load_data : 64'd0;
            o_mem_lam       <= w_wb_v_nxt & (r_state == IDLE) & w_is_load & w_misal;
            o_mem_sam       <= w_wb_v_nxt & (r_state == IDLE) & w_is_store & w_misal;
            o_mem_laf       <= w_wb_v_nxt & w_done & w_fault & ~w_sel_we;
            o_mem_saf       <= w_wb_v_nxt & w_done & w_fault & w_sel_we;
        end else begin
            o_wb_v    <= 1'b0;
            o_mem_lam <= 1'b0;
            o_mem_laf <= 1'b0;
            o_mem_sam <= 1'b0;
            o_mem_saf <= 1'b0;
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Bench for mem_stage: hand-written vector table, randomized ops against a reference
// model, and short sequences for flush, drain and reset during an outstanding access.
module tb_mem_stage;

    localparam int T = 4;
    localparam logic [6:0] OP_LD = 7'b0000011;
    localparam logic [6:0] OP_ST = 7'b0100011;
    localparam logic [6:0] OP_R  = 7'b0110011;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_v = 1'b0;
    logic [63:0] mem_ir = '0;
    logic [63:0] mem_npc = '0;
    logic [63:0] mem_alu = '0;
    logic [63:0] mem_sr2 = '0;
    logic [63:0] mem_csrfd = '0;
    logic [63:0] mem_rfd = '0;
    logic [4:0]  mem_drid = '0;
    logic        mem_pc_mux = 1'b0;
    logic        mem_ecall = 1'b0;
    logic        flush = 1'b0;
    logic        dmem_ready = 1'b0;
    logic [63:0] dmem_rdata = '0;
    logic        dmem_err = 1'b0;
    logic        dmem_req, dmem_we, mem_stall, wb_v, wb_pc_mux, wb_ecall;
    logic [63:0] dmem_addr, dmem_wdata, wb_npc, wb_mem_result, wb_alu, wb_ir, wb_csrfd, wb_rfd;
    logic [7:0]  dmem_wstrb;
    logic [4:0]  wb_drid;
    logic        mem_lam, mem_laf, mem_sam, mem_saf;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_stage #(.TIMEOUT_CYCLES(T)) dut (
        .i_clk(clk), .i_reset(reset), .i_mem_v(mem_v), .i_mem_ir(mem_ir),
        .i_mem_npc(mem_npc), .i_mem_alu_result(mem_alu), .i_mem_sr2(mem_sr2),
        .i_mem_csrfd(mem_csrfd), .i_mem_rfd(mem_rfd), .i_mem_drid(mem_drid),
        .i_mem_pc_mux(mem_pc_mux), .i_mem_ecall(mem_ecall), .i_flush(flush),
        .i_dmem_ready(dmem_ready), .i_dmem_rdata(dmem_rdata), .i_dmem_err(dmem_err),
        .o_dmem_req(dmem_req), .o_dmem_we(dmem_we), .o_dmem_addr(dmem_addr),
        .o_dmem_wdata(dmem_wdata), .o_dmem_wstrb(dmem_wstrb), .o_mem_stall(mem_stall),
        .o_wb_v(wb_v), .o_wb_npc(wb_npc), .o_wb_mem_result(wb_mem_result),
        .o_wb_alu_result(wb_alu), .o_wb_ir(wb_ir), .o_wb_pc_mux(wb_pc_mux),
        .o_wb_csrfd(wb_csrfd), .o_wb_rfd(wb_rfd), .o_wb_drid(wb_drid),
        .o_wb_ecall(wb_ecall), .o_mem_lam(mem_lam), .o_mem_laf(mem_laf),
        .o_mem_sam(mem_sam), .o_mem_saf(mem_saf)
    );

    typedef struct {
        logic [6:0]  opc;
        logic [2:0]  f3;
        logic [63:0] addr;
        logic [63:0] sr2;
        logic [63:0] rdata;
        logic        err;
        int          lat;
        logic        e_req;
        logic [63:0] e_addr;
        logic [63:0] e_wdata;
        logic [7:0]  e_wstrb;
        int          e_done;
        logic [63:0] e_res;
        logic        e_lam, e_laf, e_sam, e_saf;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic vec_t mkv(input logic [6:0] opc, input logic [2:0] f3,
                                 input logic [63:0] addr, input logic [63:0] sr2,
                                 input logic [63:0] rdata, input logic err, input int lat,
                                 input logic e_req, input logic [63:0] e_addr,
                                 input logic [63:0] e_wdata, input logic [7:0] e_wstrb,
                                 input int e_done, input logic [63:0] e_res,
                                 input logic lam, input logic laf, input logic sam, input logic saf);
        vec_t v;
        v.opc = opc; v.f3 = f3; v.addr = addr; v.sr2 = sr2; v.rdata = rdata;
        v.err = err; v.lat = lat; v.e_req = e_req; v.e_addr = e_addr;
        v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_done = e_done; v.e_res = e_res;
        v.e_lam = lam; v.e_laf = laf; v.e_sam = sam; v.e_saf = saf;
        return v;
    endfunction

    // Reference model: expected bus request, latency and result straight from the access rules.
    function automatic vec_t model(input logic [6:0] opc, input logic [2:0] f3,
                                   input logic [63:0] addr, input logic [63:0] sr2,
                                   input logic [63:0] rdata, input logic err, input int lat);
        vec_t v;
        bit ld, st, mis, fault;
        int size, off;
        logic [63:0] val, m;
        v = mkv(opc, f3, addr, sr2, rdata, err, lat, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        ld   = (opc == OP_LD);
        st   = (opc == OP_ST) && (f3 < 4);
        size = 1 << f3[1:0];
        off  = int'(addr % 8);
        mis  = (off % size) != 0;
        if (!(ld || st)) return v;
        if (mis) begin
            v.e_lam = ld;
            v.e_sam = st;
            return v;
        end
        v.e_req   = 1;
        v.e_addr  = addr & ~64'd7;
        v.e_wstrb = 8'(((1 << size) - 1) << off);
        v.e_wdata = sr2 << (8 * off);
        v.e_done  = (lat <= T) ? lat : T;
        fault     = (lat > T) || err;
        v.e_laf   = ld && fault;
        v.e_saf   = st && fault;
        if (ld && !fault) begin
            val = rdata >> (8 * off);
            if (size < 8) begin
                m = (64'd1 << (8 * size)) - 64'd1;
                val = val & m;
                if (f3 < 4 && val[8 * size - 1]) val = val | ~m;
            end
            v.e_res = val;
        end
        return v;
    endfunction

    task automatic run_op(input vec_t v);
        logic [63:0] npc, csrfd, rfd, ir;
        logic [4:0]  drid;
        logic        pcm, ecl;
        npc   = {$urandom, $urandom};
        csrfd = {$urandom, $urandom};
        rfd   = {$urandom, $urandom};
        drid  = 5'($urandom);
        pcm   = 1'($urandom);
        ecl   = 1'($urandom);
        ir    = {$urandom, 17'($urandom), v.f3, 5'($urandom), v.opc};
        @(negedge clk);
        mem_v = 1'b1; mem_ir = ir; mem_npc = npc; mem_alu = v.addr; mem_sr2 = v.sr2;
        mem_csrfd = csrfd; mem_rfd = rfd; mem_drid = drid; mem_pc_mux = pcm;
        mem_ecall = ecl; flush = 1'b0;
        for (int c = 0; c <= v.e_done; c++) begin
            if (c > 0) @(negedge clk);
            dmem_ready = (c == v.lat);
            dmem_rdata = (c == v.lat) ? v.rdata : {$urandom, $urandom};
            dmem_err   = (c == v.lat) ? v.err : 1'($urandom);
            #1;
            chk("dmem_req", dmem_req, v.e_req);
            if (v.e_req) begin
                chk("dmem_addr", dmem_addr, v.e_addr);
                chk("dmem_wdata", dmem_wdata, v.e_wdata);
                chk("dmem_wstrb", dmem_wstrb, v.e_wstrb);
                chk("dmem_we", dmem_we, v.opc == OP_ST);
            end
            chk("mem_stall", mem_stall, c < v.e_done);
            @(posedge clk); #1;
            chk("wb_v", wb_v, c == v.e_done);
        end
        chk("wb_mem_result", wb_mem_result, v.e_res);
        chk("mem_lam", mem_lam, v.e_lam);
        chk("mem_laf", mem_laf, v.e_laf);
        chk("mem_sam", mem_sam, v.e_sam);
        chk("mem_saf", mem_saf, v.e_saf);
        chk("wb_npc", wb_npc, npc);
        chk("wb_alu_result", wb_alu, v.addr);
        chk("wb_ir", wb_ir, ir);
        chk("wb_misc", {wb_csrfd ^ wb_rfd, wb_drid, wb_pc_mux, wb_ecall} ,
            {csrfd ^ rfd, drid, pcm, ecl});
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        mem_v = 1'b0; flush = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0;
        #1;
        chk("idle_req", dmem_req, 1'b0);
        chk("idle_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        chk("idle_wb_v", wb_v, 1'b0);
    endtask

    vec_t tbl[14];

    initial begin
        tbl[0]  = mkv(OP_LD, 3'b011, 64'h1000, 64'h0, 64'h1122334455667788, 0, 0,
                      1, 64'h1000, 64'h0, 8'hFF, 0, 64'h1122334455667788, 0, 0, 0, 0);
        tbl[1]  = mkv(OP_LD, 3'b000, 64'h1003, 64'h0, 64'h0000000080FFFFFF, 0, 3,
                      1, 64'h1000, 64'h0, 8'h08, 3, 64'hFFFFFFFFFFFFFF80, 0, 0, 0, 0);
        tbl[2]  = mkv(OP_LD, 3'b100, 64'h1003, 64'h0, 64'h0000000080FFFFFF, 0, 1,
                      1, 64'h1000, 64'h0, 8'h08, 1, 64'h80, 0, 0, 0, 0);
        tbl[3]  = mkv(OP_ST, 3'b001, 64'h2006, 64'hABCD, 64'h0, 0, 0,
                      1, 64'h2000, 64'hABCD000000000000, 8'hC0, 0, 64'h0, 0, 0, 0, 0);
        tbl[4]  = mkv(OP_LD, 3'b010, 64'h1002, 64'h0, 64'h0, 0, 0,
                      0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 1, 0, 0, 0);
        tbl[5]  = mkv(OP_ST, 3'b011, 64'h1004, 64'h55, 64'h0, 0, 0,
                      0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 0, 0, 1, 0);
        tbl[6]  = mkv(OP_LD, 3'b011, 64'h1008, 64'h0, 64'hFFFF0000FFFF0000, 1, 0,
                      1, 64'h1008, 64'h0, 8'hFF, 0, 64'h0, 0, 1, 0, 0);
        tbl[7]  = mkv(OP_LD, 3'b011, 64'h1010, 64'h0, 64'h0, 0, 99,
                      1, 64'h1010, 64'h0, 8'hFF, 4, 64'h0, 0, 1, 0, 0);
        tbl[8]  = mkv(OP_LD, 3'b001, 64'h3002, 64'h0, 64'h0000000080011234, 0, 2,
                      1, 64'h3000, 64'h0, 8'h0C, 2, 64'hFFFFFFFFFFFF8001, 0, 0, 0, 0);
        tbl[9]  = mkv(OP_LD, 3'b110, 64'h3004, 64'h0, 64'hDEADBEEF00000000, 0, 4,
                      1, 64'h3000, 64'h0, 8'hF0, 4, 64'h00000000DEADBEEF, 0, 0, 0, 0);
        tbl[10] = mkv(OP_ST, 3'b010, 64'h4004, 64'h12345678, 64'h0, 1, 1,
                      1, 64'h4000, 64'h1234567800000000, 8'hF0, 1, 64'h0, 0, 0, 0, 1);
        tbl[11] = mkv(OP_R, 3'b000, 64'h1001, 64'h0, 64'h0, 0, 0,
                      0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 0, 0, 0, 0);
        tbl[12] = mkv(OP_ST, 3'b100, 64'h1001, 64'h0, 64'h0, 0, 0,
                      0, 64'h0, 64'h0, 8'h00, 0, 64'h0, 0, 0, 0, 0);
        tbl[13] = mkv(OP_ST, 3'b000, 64'h5007, 64'h123456789ABCDE5A, 64'h0, 0, 0,
                      1, 64'h5000, 64'h5A00000000000000, 8'h80, 0, 64'h0, 0, 0, 0, 0);

        // Reset state, with a load presented so a leaking request would be visible.
        @(negedge clk);
        mem_v = 1'b1; mem_ir = {49'd0, 3'b011, 5'd0, OP_LD}; mem_alu = 64'h1000;
        #1;
        chk("rst_req", dmem_req, 1'b0);
        chk("rst_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        chk("rst_wb_v", wb_v, 1'b0);
        chk("rst_flags", {mem_lam, mem_laf, mem_sam, mem_saf}, 4'b0);
        chk("rst_wb_result", wb_mem_result, 64'h0);
        @(negedge clk);
        reset = 1'b0; mem_v = 1'b0;

        foreach (tbl[i]) run_op(tbl[i]);
        idle_cycle();

        for (int k = 0; k < 80; k++) begin
            logic [6:0] opc;
            int sel;
            sel = $urandom_range(0, 5);
            opc = (sel < 3) ? OP_LD : (sel < 5) ? OP_ST : OP_R;
            run_op(model(opc, 3'($urandom), {$urandom, $urandom}, {$urandom, $urandom},
                         {$urandom, $urandom}, $urandom_range(0, 3) == 0,
                         $urandom_range(0, 6)));
            if ($urandom_range(0, 3) == 0) idle_cycle();
        end

        // Flush while BUSY: request held through the drain, no WB result, stall until READY.
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            mem_ir = {49'd0, 3'b011, 5'd1, OP_LD}; mem_alu = 64'h6000;
            mem_v = (c < 2); flush = (c == 1); dmem_ready = (c == 3); dmem_err = 1'b0;
            #1;
            chk("drain_req", dmem_req, c < 4);
            if (c < 4) chk("drain_addr", dmem_addr, 64'h6000);
            chk("drain_stall", mem_stall, c < 4);
            @(posedge clk); #1;
            chk("drain_wb_v", wb_v, 1'b0);
        end

        // Flush together with READY in IDLE: nothing reaches WB.
        @(negedge clk);
        mem_v = 1'b1; flush = 1'b1; dmem_ready = 1'b1; dmem_err = 1'b1;
        mem_ir = {49'd0, 3'b011, 5'd2, OP_LD}; mem_alu = 64'h7000;
        #1;
        chk("fl_idle_req", dmem_req, 1'b0);
        chk("fl_idle_stall", mem_stall, 1'b0);
        @(posedge clk); #1;
        chk("fl_idle_wb_v", wb_v, 1'b0);
        chk("fl_idle_laf", mem_laf, 1'b0);

        // Reset in the middle of BUSY.
        @(negedge clk);
        flush = 1'b0; dmem_ready = 1'b0; dmem_err = 1'b0; mem_alu = 64'h7008;
        #1;
        chk("rb_issue_req", dmem_req, 1'b1);
        @(posedge clk);
        @(negedge clk);
        reset = 1'b1;
        #1;
        chk("rb_req_in_reset", dmem_req, 1'b0);
        chk("rb_stall_in_reset", mem_stall, 1'b0);
        @(posedge clk); #1;
        chk("rb_wb_v", wb_v, 1'b0);
        @(negedge clk);
        reset = 1'b0; mem_v = 1'b0;
        #1;
        chk("rb_req_after", dmem_req, 1'b0);
        chk("rb_stall_after", mem_stall, 1'b0);
        @(posedge clk); #1;
        run_op(tbl[0]);
        idle_cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Pipeline stage directly upstream of writeback; executes loads and stores against the data memory and registers all stage results into the WB_* pipeline latch.
- Performs alignment checks, byte-lane steering, load sign/zero extension, bus-error and timeout detection. Raises MEM_LAM/LAF/SAM/SAF toward the trap handler.
- Stalls the upstream pipeline while a memory access is outstanding.

Parameters:
- TIMEOUT_CYCLES, 255: maximum BUSY cycles without DMEM_READY before the access is reported as a fault.

Ports:
- CLK  in  1  clock
- RESET  in  1  synchronous active-high reset
- MEM_V  in  1  valid instruction in stage
- MEM_IR  in  64  instruction ([6:0] opcode, [14:12] funct3)
- MEM_NPC  in  64  next PC
- MEM_ALU_RESULT  in  64  effective address / ALU result
- MEM_SR2  in  64  store data
- MEM_CSRFD, MEM_RFD  in  64 each  CSR path data, passed through
- MEM_DRID  in  5  destination register
- MEM_PC_MUX, MEM_ECALL  in  1 each  passed through
- FLUSH  in  1  trap/redirect from writeback; kill the stage
- DMEM_READY  in  1  memory accepts/completes the request this cycle
- DMEM_RDATA  in  64  read data, valid with DMEM_READY
- DMEM_ERR  in  1  access fault, valid with DMEM_READY
- DMEM_REQ  out  1  request valid
- DMEM_WE  out  1  1 = store
- DMEM_ADDR  out  64  doubleword-aligned address (addr & ~7)
- DMEM_WDATA  out  64  store data shifted to its lane
- DMEM_WSTRB  out  8  byte enables
- MEM_STALL  out  1  hold upstream
- WB_V, WB_NPC, WB_MEM_RESULT, WB_ALU_RESULT, WB_IR, WB_PC_MUX, WB_CSRFD, WB_RFD, WB_DRID, WB_ECALL  out  (widths as inputs)  registered WB latch
- MEM_LAM, MEM_LAF, MEM_SAM, MEM_SAF  out  1 each  registered, aligned with WB_V

Behaviour:
- Memop decode: load = opcode 0000011, store = 0100011, qualified by MEM_V.
- Size from funct3[1:0]: 1/2/4/8 bytes. Load funct3 100/101/110 = LBU/LHU/LWU (zero-extend); 000–011 sign-extend. Store funct3 > 011 is not a memop here.
- Misaligned (address low bits not a multiple of size): no DMEM_REQ. The instruction completes in 1 cycle with LAM or SAM = 1 and WB_MEM_RESULT = 0.
- Lanes: DMEM_WSTRB = size mask << addr[2:0]. DMEM_WDATA = MEM_SR2 << 8*addr[2:0]. Load result = (DMEM_RDATA >> 8*addr[2:0]), then truncated and extended.
- FSM states IDLE, BUSY, DRAIN. Reset → IDLE.
- IDLE, aligned memop, !FLUSH:
  - DMEM_REQ = 1 combinationally from the inputs.
  - If DMEM_READY: complete this edge.
  - Else latch ADDR/WDATA/WSTRB/WE/size/addr-offset, clear the timeout counter, go to BUSY.
- BUSY:
  - DMEM_REQ = 1 from the latched fields; the request is held stable until READY.
  - On READY: complete, go to IDLE.
  - Counter reaching TIMEOUT_CYCLES: complete as a fault (LAF/SAF), go to IDLE.
  - FLUSH: go to DRAIN.
- DRAIN:
  - DMEM_REQ held from the latched fields; no WB result.
  - On READY or timeout: go to IDLE.
- MEM_STALL = (IDLE & aligned memop & !READY & !FLUSH) | BUSY&!READY&!timeout | DRAIN.
- Completion: DMEM_ERR = 1 sets LAF (load) or SAF (store), with WB_MEM_RESULT = 0.
- WB latch loads every cycle MEM_STALL = 0.
  - WB_V ← MEM_V & !FLUSH.
  - While stalled, WB_V ← 0 (bubble) and the other WB fields hold.
  - Exception flags are only set when WB_V ← 1; otherwise 0.
- Non-memop: 1-cycle latency, WB_MEM_RESULT = 0, no DMEM_REQ.
- FLUSH and DMEM_READY in the same cycle in IDLE: the transaction already happened; the result is dropped (WB_V ← 0).
- Reset: all outputs 0, FSM IDLE, counter 0. This applies mid-transaction too; the bus request drops immediately.

Test Plan:
- LD at 0x1000, DMEM_READY tied 1, RDATA 0x1122334455667788 → next edge WB_V = 1, WB_MEM_RESULT = 0x1122334455667788, MEM_STALL never high.
- LB at 0x1003, RDATA 0x00000000_80FFFFFF, READY after 3 cycles → MEM_STALL high for 3 cycles, WB_V bubbles. Result: byte 3 = 0x80, WB_MEM_RESULT = 0xFFFFFFFFFFFFFF80. LBU gives 0x80.
- SH at 0x2006, SR2 = 0xABCD → DMEM_ADDR = 0x2000, WSTRB = 0xC0, WDATA[63:48] = 0xABCD, WE = 1.
- LW at 0x1002 → no DMEM_REQ, next edge WB_V = 1, MEM_LAM = 1. SD at 0x1004 → MEM_SAM = 1.
- LD with READY and DMEM_ERR = 1 → MEM_LAF = 1, WB_MEM_RESULT = 0. LD never READY with TIMEOUT_CYCLES = 4 → LAF after 4 BUSY cycles, stall released.
- FLUSH in BUSY cycle 1, READY in cycle 3 → DMEM_REQ held with the same address through cycle 3, WB_V = 0 throughout, MEM_STALL drops after READY. RESET mid-BUSY → DMEM_REQ = 0 next cycle.
